fetch_seq: RTL
==============

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter TIMEOUT, 16, watchdog limit in cycles per byte request; used only when FETCH_SEQ_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 start  input  1  request to fetch one instruction at pc; sampled only in IDLE.
REQ-005 flush  input  1  abandon the current fetch and return to IDLE.
REQ-006 pc  input  64  instruction address, captured when start is accepted.
REQ-007 mem_req  output  1  byte read request, held high until acknowledged.
REQ-008 mem_addr  output  64  byte address, valid while mem_req is high.
REQ-009 mem_rdata  input  8  read byte, valid when mem_rvalid is high.
REQ-010 mem_rvalid  input  1  read acknowledge; ignored while mem_req is low.
REQ-011 busy  output  1  high in FETCH state.
REQ-012 done  output  1  one-cycle pulse when a decoded instruction is valid.
REQ-013 icode, ifun, rA, rB  output  4 each  decoded fields.
REQ-014 valC  output  64  constant word, little-endian assembled.
REQ-015 valP  output  64  pc plus instruction length, modulo 2^64.
REQ-016 instr_err  output  1  invalid icode or timeout; valid with done.

Function
REQ-017 States SHALL be IDLE, FETCH and DONE; IDLE->FETCH on start, FETCH->DONE after the last byte is captured, DONE->IDLE unconditionally after one cycle.
REQ-018 In FETCH, mem_req SHALL be high and mem_addr SHALL equal captured pc plus byte index idx (0-based), wrapping modulo 2^64.
REQ-019 A byte SHALL be captured on each edge where mem_req and mem_rvalid are both high, then idx increments; only one request is outstanding at a time.
REQ-020 Byte 0 SHALL set icode=[7:4], ifun=[3:0] and fix length L: icode 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C-F -> 1 with instr_err=1.
REQ-021 For L=2 and L=10, byte 1 SHALL set rA=[7:4], rB=[3:0]; otherwise rA=rB=0xF.
REQ-022 valC SHALL be bytes 1..8 for L=9 and bytes 2..9 for L=10, with the lowest address as the least significant byte; otherwise valC=0.
REQ-023 done SHALL be high only in DONE; with mem_rvalid held high, done asserts exactly L+1 cycles after the start-accept edge.
REQ-024 Outputs SHALL hold their values from DONE until the next start is accepted.
REQ-025 start SHALL be ignored outside IDLE; start in DONE SHALL be ignored and must be re-presented in IDLE.
REQ-026 flush SHALL force IDLE on the next edge from any state: no done, mem_req low, decoded outputs unchanged; flush wins over a simultaneous start or mem_rvalid.
REQ-027 A mem_rvalid that arrives in the same cycle as a flush SHALL be discarded.

Reset
REQ-028 When rst_n is low at an edge, the block SHALL enter IDLE with mem_req=0, mem_addr=0, busy=0, done=0, icode=ifun=0, rA=rB=0xF, valC=0, valP=0, instr_err=0 and idx=0, aborting any fetch in progress.

Configuration
REQ-029 When FETCH_SEQ_TIMEOUT_EN is defined, a counter SHALL reset on each capture; if TIMEOUT cycles pass in FETCH without a capture, the block SHALL go to DONE with instr_err=1 and the partially assembled fields.
REQ-030 When FETCH_SEQ_TIMEOUT_EN is undefined, no counter SHALL exist and FETCH waits indefinitely.

Verification
REQ-031 pc=0x100, bytes 30 F3 0A 00 00 00 00 00 00 00, mem_rvalid=1 -> done 11 cycles after start; icode=3, ifun=0, rA=F, rB=3, valC=0xA, valP=0x10A.
REQ-032 pc=0x20, bytes 80 40 00 00 00 00 00 00 00 -> icode=8, rA=rB=F, valC=0x40, valP=0x29, 9 mem_req acknowledges.
REQ-033 pc=0xFFFFFFFFFFFFFFFF, byte 60, then 12 -> mem_addr 0xFF..FF then 0x0; valP=0x1; rA=1, rB=2.
REQ-034 Byte 0 = 0xD5 -> done after 1 byte, instr_err=1, icode=D; flush after the 3rd byte of an L=10 fetch -> IDLE next cycle, no done pulse.
REQ-035 rvalid delayed 3 cycles per byte -> mem_addr stable while waiting; with the macro defined and mem_rvalid stuck low for 16 cycles -> done with instr_err=1.

Source files
------------

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - byte-serial instruction fetch and decode sequencer
// Optional watchdog: define FETCH_SEQ_TIMEOUT_EN to enable the per-byte TIMEOUT counter.
module fetch_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [63:0] pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [3:0]  r_idx;
    logic [3:0]  r_len;
    logic        r_len_vld;

    // Fields under assembly; published to the outputs only on the FETCH->DONE edge
    logic [3:0]  r_wk_icode;
    logic [3:0]  r_wk_ifun;
    logic [3:0]  r_wk_ra;
    logic [3:0]  r_wk_rb;
    logic [63:0] r_wk_valc;
    logic        r_wk_err;

    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic        r_err;

    logic        w_all_bytes;
    logic        w_mem_req;
    logic        w_cap;
    logic        w_timeout;
    logic        w_commit;
    logic        w_len_mode2;

    function automatic logic [3:0] len_of(input logic [3:0] code);
        case (code)
            4'h0, 4'h1, 4'h9:       len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction

    assign w_all_bytes = r_len_vld && (r_idx == r_len);
    assign w_mem_req   = (r_state == S_FETCH) && !w_all_bytes;
    assign w_cap       = w_mem_req && mem_rvalid && !flush;
    assign w_len_mode2 = (r_len == 4'd2) || (r_len == 4'd10);

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] r_tcnt;

    assign w_timeout = w_mem_req && !w_cap && !flush && (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if ((r_state != S_FETCH) || w_cap) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_all_bytes || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    assign w_commit = (r_state == S_FETCH) && (w_state_nxt == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_len_vld  <= 1'b0;
            r_wk_icode <= '0;
            r_wk_ifun  <= '0;
            r_wk_ra    <= 4'hF;
            r_wk_rb    <= 4'hF;
            r_wk_valc  <= '0;
            r_wk_err   <= 1'b0;
            r_icode    <= '0;
            r_ifun     <= '0;
            r_ra       <= 4'hF;
            r_rb       <= 4'hF;
            r_valc     <= '0;
            r_valp     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start && !flush) begin
                r_pc       <= pc;
                r_idx      <= '0;
                r_len      <= '0;
                r_len_vld  <= 1'b0;
                r_wk_icode <= '0;
                r_wk_ifun  <= '0;
                r_wk_ra    <= 4'hF;
                r_wk_rb    <= 4'hF;
                r_wk_valc  <= '0;
                r_wk_err   <= 1'b0;
            end
            if (w_cap) begin
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd0) begin
                    r_wk_icode <= mem_rdata[7:4];
                    r_wk_ifun  <= mem_rdata[3:0];
                    r_len      <= len_of(mem_rdata[7:4]);
                    r_len_vld  <= 1'b1;
                    r_wk_err   <= (mem_rdata[7:6] == 2'b11);
                end else if ((r_idx == 4'd1) && w_len_mode2) begin
                    r_wk_ra <= mem_rdata[7:4];
                    r_wk_rb <= mem_rdata[3:0];
                end else if (r_len == 4'd9) begin
                    r_wk_valc[{r_idx - 4'd1, 3'b000} +: 8] <= mem_rdata;
                end else if (r_len == 4'd10) begin
                    r_wk_valc[{r_idx - 4'd2, 3'b000} +: 8] <= mem_rdata;
                end
            end
            if (w_commit) begin
                r_icode <= r_wk_icode;
                r_ifun  <= r_wk_ifun;
                r_ra    <= r_wk_ra;
                r_rb    <= r_wk_rb;
                r_valc  <= r_wk_valc;
                r_valp  <= r_pc + {60'd0, r_len};
                r_err   <= r_wk_err | w_timeout;
            end
        end
    end

    assign mem_req   = w_mem_req;
    assign mem_addr  = w_mem_req ? (r_pc + {60'd0, r_idx}) : 64'd0;
    assign busy      = (r_state == S_FETCH);
    assign done      = (r_state == S_DONE);
    assign icode     = r_icode;
    assign ifun      = r_ifun;
    assign rA        = r_ra;
    assign rB        = r_rb;
    assign valC      = r_valc;
    assign valP      = r_valp;
    assign instr_err = r_err;

endmodule
